// File: rtl/wb_arbiter.sv
// wb_arbiter: merges load and ALU results onto one register-file write port, with a load-priority ALU holding FIFO, busy mask and sticky WAW error flag
module wb_arbiter #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [$clog2(DEPTH)-1:0] alu_rd,
  input  logic [WIDTH-1:0]         alu_data,
  input  logic                     ld_valid,
  input  logic [$clog2(DEPTH)-1:0] ld_rd,
  input  logic [WIDTH-1:0]         ld_data,
  output logic                     we0,
  output logic [$clog2(DEPTH)-1:0] wr_addr0,
  output logic [WIDTH-1:0]         wr_din0,
  output logic [DEPTH-1:0]         busy,
  output logic                     err
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [AW-1:0] q_rd [FIFO_DEPTH];
  logic [WIDTH-1:0] q_data [FIFO_DEPTH];
  logic [PW:0] wptr, rptr, cnt;
  logic full, empty, ld_go, alu_go, deq, byp, enq, sel, viol;
  assign cnt = wptr - rptr;
  assign empty = wptr == rptr;
  assign full = (wptr ^ rptr) == {1'b1, {PW{1'b0}}};
  assign alu_ready = !full && !rst;
  assign ld_go = ld_valid && ld_rd != '0;
  assign alu_go = alu_valid && alu_ready && alu_rd != '0;
  assign deq = !ld_go && !empty;
  assign byp = !ld_go && empty && alu_go;
  assign enq = alu_go && !byp;
  assign sel = ld_go || deq || byp;
  assign viol = ld_go && busy[ld_rd];
  always_comb begin
    busy = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if ((PW+1)'(i) < cnt) busy[q_rd[PW'(rptr + (PW+1)'(i))]] = 1'b1;
    if (we0) busy[wr_addr0] = 1'b1;
    busy[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      we0 <= 1'b0;
      wr_addr0 <= '0;
      wr_din0 <= '0;
      err <= 1'b0;
    end else begin
      we0 <= sel;
      if (sel) begin
        wr_addr0 <= ld_go ? ld_rd : deq ? q_rd[rptr[PW-1:0]] : alu_rd;
        wr_din0 <= ld_go ? ld_data : deq ? q_data[rptr[PW-1:0]] : alu_data;
      end
      if (deq) rptr <= rptr + (PW+1)'(1);
      if (enq) begin
        q_rd[wptr[PW-1:0]] <= alu_rd;
        q_data[wptr[PW-1:0]] <= alu_data;
        wptr <= wptr + (PW+1)'(1);
      end
      err <= err | viol;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: random and directed checks of wb_arbiter against a queue-based reference model
module tb_wb_arbiter;
  localparam int FD = 2;
  logic clk = 0, rst = 1;
  logic alu_valid = 0, ld_valid = 0, alu_ready, we0, err;
  logic [4:0] alu_rd = 0, ld_rd = 0, wr_addr0;
  logic [31:0] alu_data = 0, ld_data = 0, wr_din0, busy;
  typedef struct {logic [4:0] rd; logic [31:0] d;} ent_t;
  ent_t q[$];
  logic m_we = 0, m_err = 0;
  logic [4:0] m_addr = 0;
  logic [31:0] m_din = 0;
  bit last_acc;
  logic [4:0] wr_log[$];
  int total = 0, bad = 0;
  wb_arbiter #(.WIDTH(32), .DEPTH(32), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
    .alu_data(alu_data), .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .we0(we0),
    .wr_addr0(wr_addr0), .wr_din0(wr_din0), .busy(busy), .err(err));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mbusy();
    logic [31:0] b = '0;
    foreach (q[i]) b[q[i].rd] = 1'b1;
    if (m_we) b[m_addr] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction
  task automatic step(input bit r, input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ldd);
    bit rdy, acc;
    logic [31:0] b;
    ent_t e;
    @(negedge clk);
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_data = ldd;
    rdy = !r && q.size() < FD;
    #1 chk("alu_ready", alu_ready, rdy);
    acc = av && rdy;
    last_acc = acc;
    if (r) begin
      q.delete();
      m_we = 0; m_addr = 0; m_din = 0; m_err = 0;
    end else begin
      b = mbusy();
      if (lv && lrd != 0 && b[lrd]) m_err = 1;
      if (lv && lrd != 0) begin
        m_we = 1; m_addr = lrd; m_din = ldd;
        if (acc && ard != 0) q.push_back('{ard, ad});
      end else if (q.size() != 0) begin
        e = q.pop_front();
        m_we = 1; m_addr = e.rd; m_din = e.d;
        if (acc && ard != 0) q.push_back('{ard, ad});
      end else if (acc && ard != 0) begin
        m_we = 1; m_addr = ard; m_din = ad;
      end else m_we = 0;
    end
    @(posedge clk);
    #1;
    chk("we0", we0, m_we);
    chk("err", err, m_err);
    chk("busy", busy, mbusy());
    if (m_we || r) begin
      chk("wr_addr0", wr_addr0, m_addr);
      chk("wr_din0", wr_din0, m_din);
    end
    if (we0) wr_log.push_back(wr_addr0);
  endtask
  initial begin
    logic [4:0] alu_list[3];
    int j;
    step(1, 1, 5'd7, 32'h1, 1, 5'd8, 32'h2);
    chk("rst_we0", we0, 1'b0);
    step(1, 1, 5'd7, 32'h1, 1, 5'd8, 32'h2);
    chk("rst_addr", wr_addr0, 5'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_ready", alu_ready, 1'b1);
    chk("post_rst_busy", busy, 32'h0);
    step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    chk("byp_din", wr_din0, 32'hDEADBEEF);
    chk("byp_busy5", busy[5], 1'b1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("byp_idle", busy, 32'h0);
    step(0, 1, 5'd4, 32'h22, 1, 5'd3, 32'h11);
    chk("pri_ld_addr", wr_addr0, 5'd3);
    chk("pri_busy4", busy[4], 1'b1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("pri_alu_din", wr_din0, 32'h22);
    step(0, 0, 0, 0, 0, 0, 0);
    wr_log.delete();
    alu_list[0] = 5'd6; alu_list[1] = 5'd7; alu_list[2] = 5'd8;
    j = 0;
    for (int c = 0; c < 9; c++) begin
      step(0, j < 3, j < 3 ? alu_list[j] : 5'd0, 32'h600 + c, c < 4, 5'(10 + c), 32'h1000 + c);
      if (last_acc) j++;
    end
    chk("bp_count", wr_log.size(), 7);
    if (wr_log.size() == 7) begin
      chk("bp_o0", wr_log[0], 5'd10); chk("bp_o3", wr_log[3], 5'd13);
      chk("bp_o4", wr_log[4], 5'd6); chk("bp_o5", wr_log[5], 5'd7); chk("bp_o6", wr_log[6], 5'd8);
    end
    step(0, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0);
    chk("x0_we", we0, 1'b0);
    step(0, 1, 5'd9, 32'h99, 1, 5'd2, 32'h20);
    step(0, 0, 0, 0, 1, 5'd9, 32'h90);
    chk("viol_err", err, 1'b1);
    chk("viol_ld_din", wr_din0, 32'h90);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("viol_alu_din", wr_din0, 32'h99);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("err_sticky", err, 1'b1);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("err_clear", err, 1'b0);
    for (int c = 0; c < 500; c++)
      step($urandom_range(99) == 0, $urandom_range(1), 5'($urandom_range(7)), $urandom,
           $urandom_range(2) == 0, 5'($urandom_range(7)), $urandom);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
